network_sequencer: RTL

Sequencer for the per-sample conv1d network pipeline. On each rising edge of the audio sample strobe it runs this fixed order: advance the input left-shift buffers, then start each conv layer in turn, clocking the activation cache between layers, then latch the final outputs. It replaces the hand-written state machine inside the network top with a block parameterised by layer count. It also adds a conv-completion timeout and overrun/timeout diagnostics.

---
 rtl/network_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/network_sequencer.sv
// Per-sample sequencer for the conv1d network pipeline.
// Each rising edge of sample_clk runs: shift input buffers, then start/wait on
// every conv layer in turn (clocking the activation cache between layers),
// then latch the final output. A per-layer WAIT timeout aborts a stuck
// evaluation, and dropped sample edges / aborted evaluations are counted.
module network_sequencer #(
  parameter int N_LAYERS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     sample_clk,
  input  logic [N_LAYERS-1:0]                      conv_done,
  output logic                                     lsb_shift,
  output logic [N_LAYERS-1:0]                      conv_start,
  output logic [(N_LAYERS > 1 ? N_LAYERS-2 : 0):0] cache_shift,
  output logic                                     out_latch,
  output logic                                     busy,
  output logic [2:0]                               layer,
  output logic [7:0]                               overrun_count,
  output logic [7:0]                               timeout_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    START,
    WAIT,
    CACHE,
    OUTPUT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      layer_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic            prev;
  logic            sample_edge;
  logic            done_sel;
  logic            last_layer;
  logic            timer_last;
  logic            timeout_hit;

  assign sample_edge = sample_clk & ~prev;
  assign done_sel    = |(conv_done & (N_LAYERS'(1) << layer));
  assign last_layer  = (layer == 3'(N_LAYERS - 1));
  assign timer_last  = (timer == TW'(TIMEOUT - 1));

  // State, layer index, WAIT timer and sample-edge history; prev resets high
  // so a strobe already high at reset release is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      timer <= '0;
      prev  <= 1'b1;
    end else begin
      state <= state_next;
      layer <= layer_next;
      timer <= timer_next;
      prev  <= sample_clk;
    end
  end

  // Saturating diagnostics: edges that arrive while busy are dropped and
  // counted; aborted evaluations are counted on the WAIT timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_count <= '0;
      timeout_count <= '0;
    end else begin
      if (sample_edge && (state != IDLE) && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;
      if (timeout_hit && (timeout_count != 8'hFF))
        timeout_count <= timeout_count + 8'd1;
    end
  end

  // Next-state logic plus pulse outputs decoded purely from the state register,
  // so every pulse is exactly one cycle wide and at most one is high at a time.
  always_comb begin
    state_next  = state;
    layer_next  = layer;
    timer_next  = timer;
    timeout_hit = 1'b0;
    lsb_shift   = 1'b0;
    conv_start  = '0;
    cache_shift = '0;
    out_latch   = 1'b0;
    busy        = (state != IDLE);

    unique case (state)
      IDLE: begin
        layer_next = '0;
        if (sample_edge)
          state_next = SHIFT_IN;
      end
      SHIFT_IN: begin
        lsb_shift  = 1'b1;
        state_next = START;
      end
      START: begin
        conv_start = N_LAYERS'(1) << layer;
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (done_sel) begin
          state_next = last_layer ? OUTPUT : CACHE;
        end else if (timer_last) begin
          timeout_hit = 1'b1;
          layer_next  = '0;
          state_next  = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      CACHE: begin
        cache_shift = CW'(1) << layer;
        layer_next  = layer + 3'd1;
        state_next  = START;
      end
      OUTPUT: begin
        out_latch  = 1'b1;
        layer_next = '0;
        state_next = IDLE;
      end
      default: begin
        layer_next = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
